// File: rtl/solver_roundtrip_checker_if.sv
// Bus between the round-trip checker and the Solver encrypt/decrypt path.
//   raw_to_enc   : 60-bit raw word into the Solver encrypt input
//   enc_from_sol : 78-bit ciphertext from the Solver encrypt output
//   enc_to_dec   : 78-bit ciphertext into the Solver decrypt input
//   raw_from_dec : 60-bit recovered word from the Solver decrypt output
// master = checker side, slave = Solver side.
interface solver_roundtrip_checker_if;
  logic [59:0] raw_to_enc;
  logic [77:0] enc_from_sol;
  logic [77:0] enc_to_dec;
  logic [59:0] raw_from_dec;

  modport master (
    output raw_to_enc,
    input  enc_from_sol,
    output enc_to_dec,
    input  raw_from_dec
  );

  modport slave (
    input  raw_to_enc,
    output enc_from_sol,
    input  enc_to_dec,
    output raw_from_dec
  );
endinterface

// File: rtl/solver_roundtrip_checker.sv
// Round-trip self-check engine for the Solver encrypt/decrypt path.
// Generates LFSR raw words, sends them through encrypt, feeds the captured
// ciphertext back through decrypt and compares the recovered word.
// Ports:
//   Clk, Rst        : clock, synchronous active-high reset
//   start           : one-cycle pulse, starts a run from IDLE or DONE
//   inject_err      : latched at start; flips ciphertext bit 0 for the run
//   sol (master)    : Solver bus (raw_to_enc, enc_from_sol, enc_to_dec, raw_from_dec)
//   busy/done/pass  : run status (all registered)
//   vec_cnt/err_cnt : vectors compared / mismatches (saturating)
//   first_fail_idx/first_fail_raw : index and raw word of the first mismatch
module solver_roundtrip_checker #(
  parameter int unsigned LAT     = 1,
  parameter int unsigned NUM_VEC = 256,
  parameter logic [59:0] SEED    = 60'h1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic        inject_err,
  solver_roundtrip_checker_if.master sol,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] vec_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] first_fail_idx,
  output logic [59:0] first_fail_raw
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ENC,
    S_DEC,
    S_CMP,
    S_DONE
  } state_t;

  localparam logic [59:0] SEED_EFF = (SEED == '0) ? 60'h1 : SEED;
  localparam logic [7:0]  LAST_W   = 8'(LAT - 1);
  localparam logic [15:0] LAST_VEC = 16'(NUM_VEC - 1);

  state_t      state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [59:0] lfsr_q, lfsr_d;
  logic [59:0] raw_q, raw_d;
  logic [77:0] enc_q, enc_d;
  logic [59:0] dec_q, dec_d;
  logic        inj_q, inj_d;
  logic        fail_q, fail_d;
  logic [15:0] vec_q, vec_d;
  logic [15:0] err_q, err_d;
  logic [15:0] ffi_q, ffi_d;
  logic [59:0] ffr_q, ffr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    lfsr_d  = lfsr_q;
    raw_d   = raw_q;
    enc_d   = enc_q;
    dec_d   = dec_q;
    inj_d   = inj_q;
    fail_d  = fail_q;
    vec_d   = vec_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
    ffr_d   = ffr_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          vec_d   = '0;
          err_d   = '0;
          ffi_d   = '0;
          ffr_d   = '0;
          fail_d  = 1'b0;
          lfsr_d  = SEED_EFF;
          inj_d   = inject_err;
        end
      end
      S_LOAD: begin
        raw_d   = lfsr_q;
        wcnt_d  = '0;
        state_d = S_ENC;
      end
      S_ENC: begin
        // Solver output is only trusted on the last wait cycle.
        if (wcnt_q == LAST_W) begin
          enc_d   = sol.enc_from_sol ^ {77'b0, inj_q};
          wcnt_d  = '0;
          state_d = S_DEC;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      S_DEC: begin
        if (wcnt_q == LAST_W) begin
          dec_d   = sol.raw_from_dec;
          wcnt_d  = '0;
          state_d = S_CMP;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      S_CMP: begin
        if (dec_q != raw_q) begin
          if (err_q != '1) begin
            err_d = err_q + 16'd1;
          end
          if (!fail_q) begin
            fail_d = 1'b1;
            ffi_d  = vec_q;
            ffr_d  = raw_q;
          end
        end
        vec_d   = vec_q + 16'd1;
        lfsr_d  = {lfsr_q[58:0], lfsr_q[59] ^ lfsr_q[58]};
        state_d = (vec_q == LAST_VEC) ? S_DONE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_ENC) ||
             (state_d == S_DEC)  || (state_d == S_CMP);
    // done/pass lag DONE entry by one cycle and drop on the restart edge.
    done_d = (state_q == S_DONE) && (state_d == S_DONE);
    pass_d = done_d && (err_q == '0);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      lfsr_q  <= '0;
      raw_q   <= '0;
      enc_q   <= '0;
      dec_q   <= '0;
      inj_q   <= 1'b0;
      fail_q  <= 1'b0;
      vec_q   <= '0;
      err_q   <= '0;
      ffi_q   <= '0;
      ffr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      lfsr_q  <= lfsr_d;
      raw_q   <= raw_d;
      enc_q   <= enc_d;
      dec_q   <= dec_d;
      inj_q   <= inj_d;
      fail_q  <= fail_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      ffr_q   <= ffr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign sol.raw_to_enc  = raw_q;
  assign sol.enc_to_dec  = enc_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign vec_cnt         = vec_q;
  assign err_cnt         = err_q;
  assign first_fail_idx  = ffi_q;
  assign first_fail_raw  = ffr_q;

endmodule

// File: tb/tb_solver_roundtrip_checker.sv
module tb_solver_roundtrip_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [59:0] KEY = 60'h5A3C96F0E1D2B47;

  // ---------------- DUT A: identity stub, LAT=1, NUM_VEC=4 ----------------
  logic        rst_a, start_a, inj_a;
  logic        busy_a, done_a, pass_a;
  logic [15:0] vec_a, err_a, ffi_a;
  logic [59:0] ffr_a;
  logic [59:0] fraw_a;
  solver_roundtrip_checker_if sol_a ();

  assign sol_a.enc_from_sol = {18'b0, sol_a.raw_to_enc};
  assign sol_a.raw_from_dec = (fraw_a != '0 && sol_a.enc_to_dec[59:0] == fraw_a) ?
                              60'h0 : sol_a.enc_to_dec[59:0];

  solver_roundtrip_checker #(.LAT(1), .NUM_VEC(4)) dut_a (
    .Clk(clk), .Rst(rst_a), .start(start_a), .inject_err(inj_a), .sol(sol_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .vec_cnt(vec_a), .err_cnt(err_a),
    .first_fail_idx(ffi_a), .first_fail_raw(ffr_a)
  );

  // ------- DUT B: keyed stub with glitching outputs, LAT=3, NUM_VEC=256 -------
  logic        rst_b, start_b, inj_b;
  logic        busy_b, done_b, pass_b;
  logic [15:0] vec_b, err_b, ffi_b;
  logic [59:0] ffr_b;
  logic [59:0] fraw_b;
  solver_roundtrip_checker_if sol_b ();

  // Outputs are only correct once the input has been stable for LAT cycles;
  // before that they show the inverted value.
  logic [59:0] tr_e = '0;
  logic [77:0] tr_d = '0;
  int          age_e = 0;
  int          age_d = 0;
  always @(posedge clk) begin
    tr_e  <= sol_b.raw_to_enc;
    tr_d  <= sol_b.enc_to_dec;
    age_e <= (sol_b.raw_to_enc == tr_e) ? ((age_e < 1000) ? age_e + 1 : age_e) : 0;
    age_d <= (sol_b.enc_to_dec == tr_d) ? ((age_d < 1000) ? age_d + 1 : age_d) : 0;
  end
  logic [77:0] enc_ideal;
  logic [59:0] dec_ideal, dec_fault;
  logic        ok_e, ok_d;
  assign enc_ideal = {sol_b.raw_to_enc[59:42] ^ 18'h2D2D1, sol_b.raw_to_enc ^ KEY};
  assign dec_ideal = sol_b.enc_to_dec[59:0] ^ KEY;
  assign dec_fault = (fraw_b != '0 && dec_ideal == fraw_b) ? 60'h0 : dec_ideal;
  assign ok_e = (sol_b.raw_to_enc == tr_e) && (age_e + 2 >= 3);
  assign ok_d = (sol_b.enc_to_dec == tr_d) && (age_d + 2 >= 3);
  assign sol_b.enc_from_sol = ok_e ? enc_ideal : ~enc_ideal;
  assign sol_b.raw_from_dec = ok_d ? dec_fault : ~dec_fault;

  solver_roundtrip_checker #(.LAT(3), .NUM_VEC(256), .SEED(60'h0)) dut_b (
    .Clk(clk), .Rst(rst_b), .start(start_b), .inject_err(inj_b), .sol(sol_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .vec_cnt(vec_b), .err_cnt(err_b),
    .first_fail_idx(ffi_b), .first_fail_raw(ffr_b)
  );

  // ---------------- helpers / reference model ----------------
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  // n-th word of the x^60+x^59+1 sequence starting from 1.
  function automatic logic [59:0] lfsr_at(input int n);
    logic [59:0] x;
    x = 60'h1;
    for (int i = 0; i < n; i++) x = {x[58:0], x[59] ^ x[58]};
    return x;
  endfunction

  typedef struct {
    int          errs;
    logic [15:0] ffi;
    logic [59:0] ffr;
  } res_t;

  // Result of a run: a vector fails when the recovered word differs from
  // the raw word; recovery sees bit 0 flipped by inject and the stub fault.
  function automatic res_t model(input int nvec, input bit inj, input logic [59:0] fraw);
    res_t r;
    logic [59:0] x, rec;
    r.errs = 0; r.ffi = '0; r.ffr = '0;
    for (int i = 0; i < nvec; i++) begin
      x   = lfsr_at(i);
      rec = inj ? (x ^ 60'h1) : x;
      if (fraw != '0 && rec == fraw) rec = '0;
      if (rec != x) begin
        if (r.errs == 0) begin r.ffi = 16'(i); r.ffr = x; end
        r.errs++;
      end
    end
    return r;
  endfunction

  // Run on DUT A; start pulse, optional spurious start mid-run, inject toggled.
  task automatic run_a(input bit inj, input logic [59:0] fraw, input int spur_k, output int cyc);
    fraw_a = fraw;
    @(negedge clk); start_a = 1'b1; inj_a = inj;
    @(negedge clk); start_a = 1'b0; inj_a = ~inj;
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk); #1; cyc++;
      start_a = (cyc == spur_k);
      if (cyc == 1) begin
        chk("a_clear_vec", vec_a, 0);
        chk("a_clear_done", done_a, 0);
        chk("a_busy", busy_a, 1);
      end
      if ((cyc - 1) % 4 == 0 && (cyc - 1) / 4 < 4)
        chk($sformatf("a_raw%0d", (cyc - 1) / 4), sol_a.raw_to_enc, lfsr_at((cyc - 1) / 4));
      if (done_a) break;
    end
    start_a = 1'b0;
    if (!done_a) chk("a_timeout", 0, 1);
  endtask

  task automatic run_b(input bit inj, input logic [59:0] fraw, input int spur_k);
    int   cyc;
    res_t r;
    fraw_b = fraw;
    r = model(256, inj, fraw);
    @(negedge clk); start_b = 1'b1; inj_b = inj;
    @(negedge clk); start_b = 1'b0; inj_b = ~inj;
    cyc = 0;
    while (cyc < 3000) begin
      @(posedge clk); #1; cyc++;
      start_b = (cyc == spur_k);
      if (cyc == 1) begin
        chk("b_clear_err", err_b, 0);
        chk("b_clear_done", done_b, 0);
      end
      if ((cyc - 1) % 8 == 0 && (cyc - 1) / 8 < 3)
        chk($sformatf("b_raw%0d", (cyc - 1) / 8), sol_b.raw_to_enc, lfsr_at((cyc - 1) / 8));
      if (done_b) break;
    end
    start_b = 1'b0;
    if (!done_b) chk("b_timeout", 0, 1);
    chk("b_len", cyc, 256 * 8 + 1);
    chk("b_pass", pass_b, (r.errs == 0) ? 1 : 0);
    chk("b_vec", vec_b, 256);
    chk("b_err", err_b, r.errs);
    chk("b_ffi", ffi_b, r.ffi);
    chk("b_ffr", ffr_b, r.ffr);
    chk("b_busy", busy_b, 0);
  endtask

  typedef struct {
    bit          inj;
    logic [59:0] fraw;
    int          exp_err;
    bit          exp_pass;
    logic [15:0] exp_ffi;
    logic [59:0] exp_ffr;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int   cyc;
    logic [59:0] fr;

    tbl[0] = '{inj: 1'b0, fraw: 60'h0, exp_err: 0, exp_pass: 1'b1, exp_ffi: 16'd0, exp_ffr: 60'h0};
    tbl[1] = '{inj: 1'b1, fraw: 60'h0, exp_err: 4, exp_pass: 1'b0, exp_ffi: 16'd0, exp_ffr: 60'h1};
    tbl[2] = '{inj: 1'b0, fraw: 60'h4, exp_err: 1, exp_pass: 1'b0, exp_ffi: 16'd2, exp_ffr: 60'h4};
    tbl[3] = '{inj: 1'b0, fraw: 60'h8, exp_err: 1, exp_pass: 1'b0, exp_ffi: 16'd3, exp_ffr: 60'h8};

    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    inj_a = 1'b0; inj_b = 1'b0; fraw_a = '0; fraw_b = '0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;
    chk("rst_raw", sol_a.raw_to_enc, 0);
    chk("rst_enc", sol_a.enc_to_dec[63:0], 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_vec", vec_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_ffr", ffr_a, 0);

    // Table runs on A, chained: each start after the first arrives in DONE.
    for (int i = 0; i < 4; i++) begin
      run_a(tbl[i].inj, tbl[i].fraw, int'($urandom_range(1, 14)), cyc);
      chk($sformatf("a%0d_len", i), cyc, 4 * 4 + 1);
      chk($sformatf("a%0d_pass", i), pass_a, tbl[i].exp_pass);
      chk($sformatf("a%0d_vec", i), vec_a, 4);
      chk($sformatf("a%0d_err", i), err_a, tbl[i].exp_err);
      chk($sformatf("a%0d_ffi", i), ffi_a, tbl[i].exp_ffi);
      chk($sformatf("a%0d_ffr", i), ffr_a, tbl[i].exp_ffr);
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
      chk($sformatf("a%0d_hold", i), done_a, 1);
    end

    // Reset during DEC of vector 5 on B.
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    cyc = 0;
    while (cyc < 46) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 45) begin
        chk("mid_vec", vec_b, 5);
        rst_b = 1'b1;
      end
    end
    chk("mid_rst_raw", sol_b.raw_to_enc, 0);
    chk("mid_rst_enc", sol_b.enc_to_dec[63:0], 0);
    chk("mid_rst_busy", busy_b, 0);
    chk("mid_rst_vec", vec_b, 0);
    chk("mid_rst_done", done_b, 0);
    @(negedge clk); rst_b = 1'b0;

    // Randomized runs on B against the model (first begins from IDLE).
    for (int n = 0; n < 3; n++) begin
      fr = ($urandom_range(0, 2) == 0) ? 60'h0 : lfsr_at(int'($urandom_range(0, 255)));
      run_b(1'($urandom_range(0, 1)), fr, int'($urandom_range(1, 2040)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
